// File: rtl/register_rename_unit.sv
// register_rename_unit
//   Issue/rename stage in front of the reservation station. Holds the
//   architectural register file, a per-register producer-tag status table
//   and a circular free list of result tags (1..31). Each accepted
//   instruction is renamed and delivered one cycle later as operands
//   (value or tag), ready flags and a destination tag. CDB broadcasts
//   retire tags, update the register file and refill the free list.
//
//   Optional feature: define RENAME_CDB_BYPASS_EN to forward a same-cycle
//   CDB result into issuing operands. Without it, such an instruction
//   stalls one cycle and reads the updated register file.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   issue_valid/issue_ready  issue handshake (issue_ready combinational)
//   rs_addr, rt_addr         source registers
//   rd_addr, rd_we           destination register and write enable
//   control_in               opcode/ALU control, passed through
//   rs_full                  reservation station full
//   cdb_valid/tag/value      result broadcast
//   write                    one-cycle issue strobe
//   control, val1, val2      registered control and operand values
//   val1_r, val2_r           operand ready flags
//   rs_tag, rt_tag           producer tags for unready operands
//   dest_tag                 allocated tag (0 when no rename)
//   free_count               tags currently in the free list
module register_rename_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_we,
  input  logic [5:0]  control_in,
  input  logic        rs_full,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_tag,
  input  logic [31:0] cdb_value,
  output logic        write,
  output logic [5:0]  control,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic        val1_r,
  output logic        val2_r,
  output logic [4:0]  rs_tag,
  output logic [4:0]  rt_tag,
  output logic [4:0]  dest_tag,
  output logic [5:0]  free_count
);

  localparam int unsigned NUM_TAGS = 31;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 6;

  logic [DATA_W-1:0] regfile   [NUM_REGS];
  logic [TAG_W-1:0]  status    [NUM_REGS];
  logic [TAG_W-1:0]  free_list [NUM_TAGS];
  logic [TAG_W-1:0]  head, tail;

  logic              rename, bypass_stall, accept, do_pop, do_push;
  logic [TAG_W-1:0]  rs_stat, rt_stat, new_tag;
  logic              rs_hit, rt_hit;
  logic [DATA_W-1:0] op1_val, op2_val;
  logic              op1_rdy, op2_rdy;
  logic [TAG_W-1:0]  op1_tag, op2_tag;

  // Issue handshake and operand resolution from the pre-rename mapping.
  // status[0] is never written, so register 0 always resolves as ready.
  always_comb begin
    rename  = rd_we && (rd_addr != '0);
    rs_stat = status[rs_addr];
    rt_stat = status[rt_addr];
    rs_hit  = cdb_valid && (rs_stat != '0) && (rs_stat == cdb_tag);
    rt_hit  = cdb_valid && (rt_stat != '0) && (rt_stat == cdb_tag);
`ifdef RENAME_CDB_BYPASS_EN
    bypass_stall = 1'b0;
`else
    bypass_stall = issue_valid && (rs_hit || rt_hit);
`endif
    issue_ready = !rs_full && ((free_count != '0) || !rename) && !bypass_stall;
    accept      = issue_valid && issue_ready;
    do_pop      = accept && rename;
    do_push     = cdb_valid;
    new_tag     = free_list[head];

    op1_val = '0; op1_rdy = 1'b0; op1_tag = rs_stat;
    op2_val = '0; op2_rdy = 1'b0; op2_tag = rt_stat;
    if (rs_stat == '0) begin
      op1_val = regfile[rs_addr]; op1_rdy = 1'b1;
    end else if (rs_hit) begin
      // Only reachable with bypass enabled; otherwise the issue stalls.
      op1_val = cdb_value; op1_rdy = 1'b1; op1_tag = '0;
    end
    if (rt_stat == '0) begin
      op2_val = regfile[rt_addr]; op2_rdy = 1'b1;
    end else if (rt_hit) begin
      op2_val = cdb_value; op2_rdy = 1'b1; op2_tag = '0;
    end
  end

  // Register file and status table; a same-cycle rename of rd wins over
  // the CDB clearing its old tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regfile[r] <= '0;
        status[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (cdb_valid && (status[r] == cdb_tag)) begin
          regfile[r] <= cdb_value;
          status[r]  <= '0;
        end
        if (do_pop && (rd_addr == REG_W'(r))) status[r] <= new_tag;
      end
    end
  end

  // Circular free list: pop at head on rename, push retired tag at tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) free_list[i] <= TAG_W'(i + 1);
      head       <= '0;
      tail       <= '0;
      free_count <= CNT_W'(NUM_TAGS);
    end else begin
      if (do_pop)
        head <= (head == TAG_W'(NUM_TAGS - 1)) ? '0 : head + TAG_W'(1);
      if (do_push) begin
        free_list[tail] <= cdb_tag;
        tail <= (tail == TAG_W'(NUM_TAGS - 1)) ? '0 : tail + TAG_W'(1);
      end
      if (do_pop && !do_push)      free_count <= free_count - CNT_W'(1);
      else if (!do_pop && do_push) free_count <= free_count + CNT_W'(1);
    end
  end

  // Issue port registers: strobe for one cycle, payload holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write    <= 1'b0;
      control  <= '0;
      val1     <= '0;
      val2     <= '0;
      val1_r   <= 1'b0;
      val2_r   <= 1'b0;
      rs_tag   <= '0;
      rt_tag   <= '0;
      dest_tag <= '0;
    end else begin
      write <= accept;
      if (accept) begin
        control  <= control_in;
        val1     <= op1_val;
        val2     <= op2_val;
        val1_r   <= op1_rdy;
        val2_r   <= op2_rdy;
        rs_tag   <= op1_tag;
        rt_tag   <= op2_tag;
        dest_tag <= rename ? new_tag : '0;
      end
    end
  end

endmodule

// File: tb/tb_register_rename_unit.sv
module tb_register_rename_unit;

  logic        clk = 1'b0, rst = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic        rd_we = 1'b0;
  logic [5:0]  control_in = '0;
  logic        rs_full = 1'b0, cdb_valid = 1'b0;
  logic [4:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        write, val1_r, val2_r;
  logic [5:0]  control, free_count;
  logic [31:0] val1, val2;
  logic [4:0]  rs_tag, rt_tag, dest_tag;

  register_rename_unit dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_we(rd_we),
    .control_in(control_in), .rs_full(rs_full), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .write(write), .control(control),
    .val1(val1), .val2(val2), .val1_r(val1_r), .val2_r(val2_r),
    .rs_tag(rs_tag), .rt_tag(rt_tag), .dest_tag(dest_tag), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural values, producer map, free-tag FIFO and
  // the set of tags handed out but not yet broadcast.
  int unsigned m_rf [32];
  int          m_st [32];
  int          m_free [$];
  int          m_infl [$];
  int unsigned e_v1, e_v2;
  int          e_write, e_ctrl, e_r1, e_r2, e_t1, e_t2, e_dt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin m_rf[r] = 0; m_st[r] = 0; end
    m_free = {};
    m_infl = {};
    for (int t = 1; t <= 31; t++) m_free.push_back(t);
    e_write = 0; e_ctrl = 0; e_v1 = 0; e_v2 = 0;
    e_r1 = 0; e_r2 = 0; e_t1 = 0; e_t2 = 0; e_dt = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":write"},      32'(write),      32'(e_write));
    chk({where, ":control"},    32'(control),    32'(e_ctrl));
    chk({where, ":val1"},       val1,            e_v1);
    chk({where, ":val2"},       val2,            e_v2);
    chk({where, ":val1_r"},     32'(val1_r),     32'(e_r1));
    chk({where, ":val2_r"},     32'(val2_r),     32'(e_r2));
    chk({where, ":rs_tag"},     32'(rs_tag),     32'(e_t1));
    chk({where, ":rt_tag"},     32'(rt_tag),     32'(e_t2));
    chk({where, ":dest_tag"},   32'(dest_tag),   32'(e_dt));
    chk({where, ":free_count"}, 32'(free_count), 32'(m_free.size()));
  endtask

  // Operand as the reservation station should see it.
  task automatic resolve(input int s, input bit cv, input int ctag, input int unsigned cval,
                         output int unsigned v, output int rdy, output int tg);
    if (s == 0 || m_st[s] == 0) begin
      v = m_rf[s]; rdy = 1; tg = 0;
    end else if (cv && m_st[s] == ctag) begin
      v = cval; rdy = 1; tg = 0;
    end else begin
      v = 0; rdy = 0; tg = m_st[s];
    end
  endtask

  // One clock cycle: drive, check issue_ready, clock, update model, check.
  task automatic step(input bit iv, input int rs, input int rt, input int rd, input bit we,
                      input int ctrl, input bit full, input bit cv, input int ctag,
                      input int unsigned cval, input string name);
    bit ren, hazard, exp_ready, acc;
    int unsigned v1, v2;
    int r1, r2, t1, t2, nt;
    issue_valid = iv; rs_addr = 5'(rs); rt_addr = 5'(rt); rd_addr = 5'(rd);
    rd_we = we; control_in = 6'(ctrl); rs_full = full;
    cdb_valid = cv; cdb_tag = 5'(ctag); cdb_value = cval;
    #1;
    ren = we && rd != 0;
    hazard = cv && ((m_st[rs] != 0 && m_st[rs] == ctag) || (m_st[rt] != 0 && m_st[rt] == ctag));
`ifdef RENAME_CDB_BYPASS_EN
    hazard = 1'b0;
`endif
    exp_ready = !full && (m_free.size() != 0 || !ren) && !(iv && hazard);
    chk({name, ":issue_ready"}, 32'(issue_ready), 32'(exp_ready));
    acc = iv && exp_ready;
    resolve(rs, cv, ctag, cval, v1, r1, t1);
    resolve(rt, cv, ctag, cval, v2, r2, t2);
    @(posedge clk);
    #1;
    nt = 0;
    if (acc && ren) nt = m_free.pop_front();
    if (cv) begin
      for (int r = 1; r < 32; r++)
        if (m_st[r] == ctag) begin m_rf[r] = cval; m_st[r] = 0; end
      m_free.push_back(ctag);
      for (int i = 0; i < m_infl.size(); i++)
        if (m_infl[i] == ctag) begin m_infl.delete(i); break; end
    end
    if (nt != 0) begin m_st[rd] = nt; m_infl.push_back(nt); end
    e_write = acc;
    if (acc) begin
      e_ctrl = ctrl; e_v1 = v1; e_v2 = v2; e_r1 = r1; e_r2 = r2;
      e_t1 = t1; e_t2 = t2; e_dt = nt;
    end
    check_outputs(name);
    @(negedge clk);
  endtask

  task automatic idle(input string name);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, name);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic issue of independent sources.
    step(1, 1, 2, 3, 1, 6'h21, 0, 0, 0, 0, "add");
    chk("add_dest_is_1", 32'(dest_tag), 32'd1);
    chk("add_free_30", 32'(free_count), 32'd30);

    // Dependency on tag 1, then retire it through the CDB.
    step(1, 3, 0, 0, 0, 6'h02, 0, 0, 0, 0, "dep");
    chk("dep_rs_tag_1", 32'(rs_tag), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55, "cdb1");
    step(1, 3, 3, 0, 0, 6'h03, 0, 0, 0, 0, "after_cdb");
    chk("after_cdb_val1", val1, 32'h55);
    chk("after_cdb_free", 32'(free_count), 32'd31);

    // Same-cycle producer broadcast.
    step(1, 4, 4, 3, 1, 6'h04, 0, 0, 0, 0, "ren3");
    step(1, 3, 0, 0, 0, 6'h05, 0, 1, 2, 32'hAA, "bypass");
    step(1, 3, 0, 0, 0, 6'h05, 0, 0, 0, 0, "bypass_retry");
    chk("bypass_val1", val1, 32'hAA);

    // rs_full blocks; rd=0 does not rename.
    step(1, 1, 1, 5, 1, 6'h06, 1, 0, 0, 0, "rs_full");
    step(1, 1, 1, 0, 1, 6'h07, 0, 0, 0, 0, "rd0");

    // Exhaust the free list, then free tag 5 and reuse it.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 1 + (i % 31), 1, i, 0, 0, 0, 0, "fill");
    chk("empty_free", 32'(free_count), 32'd0);
    step(1, 0, 0, 7, 1, 6'h08, 0, 1, 5, 32'h1234, "free5");
    step(1, 0, 0, 7, 1, 6'h09, 0, 0, 0, 0, "reuse5");
    chk("reuse_dest_5", 32'(dest_tag), 32'd5);

    // Randomized traffic with in-flight tag retirement.
    for (int n = 0; n < 400; n++) begin
      bit cv; int ctag;
      cv = 0; ctag = 0;
      if (m_infl.size() != 0 && $urandom_range(0, 1) == 1) begin
        cv = 1; ctag = m_infl[$urandom_range(0, m_infl.size() - 1)];
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 63),
           $urandom_range(0, 7) == 0, cv, ctag, $urandom, "rand");
    end

    // Asynchronous reset mid-issue after a few renames.
    for (int i = 0; i < 4; i++) step(1, 1, 2, 8 + i, 1, 6'h0A, 0, 0, 0, 0, "pre_rst");
    issue_valid = 1'b1; rd_we = 1'b1; rd_addr = 5'd9;
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1, 9, 1, 12, 1, 6'h0B, 0, 0, 0, 0, "post_rst");
    chk("post_rst_dest_1", 32'(dest_tag), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
